uart_transmitter: RTL

- Transmit end of the board's serial link: serialises one byte per request into the frame the existing UART receiver decodes.
- Frame format: start bit 0, 8 data bits LSB first, parity bit equal to the XOR of the 8 data bits, stop bit 1.
- A one-entry holding buffer lets the host queue the next byte while the current frame is shifting out.
- Sits between the game/control logic and the tx pin; also drives the receiver in loopback benches, including deliberate error frames.

---
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_transmitter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// Host-side handshake bundle for uart_transmitter.
// Host drives data/request; transmitter returns line and status.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       send;
  logic [1:0] err_inject;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output data_in, send, err_inject,
    input  ready, tx, busy, done
  );

  modport slave (
    input  data_in, send, err_inject,
    output ready, tx, busy, done
  );
endinterface

// File: rtl/uart_transmitter.sv
// Serialises one byte per request: start, 8 data LSB first, parity, stop,
// then an idle gap; a one-entry holding buffer queues the next byte.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 3
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, GAP
  } state_e;

  localparam int GAP_CYC = CLKS_PER_BIT * GAP_BITS;
  localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    inj_q, inj_d;
  logic [7:0]    hold_q, hold_d;
  logic [1:0]    hinj_q, hinj_d;
  logic          hvld_q, hvld_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic accept, bit_end, gap_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    inj_d   = inj_q;
    hold_d  = hold_q;
    hinj_d  = hinj_q;
    hvld_d  = hvld_q;
    accept  = bus.send && ready_q;
    bit_end = (cnt_q == BIT_LAST);
    gap_end = (cnt_q == GAP_LAST);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = START;
          shreg_d = bus.data_in;
          inj_d   = bus.err_inject;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_end) begin
          cnt_d = '0;
          if (hvld_q) begin
            state_d = START;
            shreg_d = hold_q;
            inj_d   = hinj_q;
            hvld_d  = 1'b0;
          end else if (accept) begin
            state_d = START;
            shreg_d = bus.data_in;
            inj_d   = bus.err_inject;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A request on the final gap edge starts directly, so it is not held.
    if (accept && state_q != IDLE &&
        !(state_q == GAP && gap_end)) begin
      hold_d = bus.data_in;
      hinj_d = bus.err_inject;
      hvld_d = 1'b1;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[idx_d];
      PARITY:  tx_d = (^shreg_d) ^ inj_d[0];
      STOP:    tx_d = ~inj_d[1];
      default: tx_d = 1'b1;
    endcase

    ready_d = ~hvld_d;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (cnt_d == BIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      inj_q   <= '0;
      hold_q  <= '0;
      hinj_q  <= '0;
      hvld_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      inj_q   <= inj_d;
      hold_q  <= hold_d;
      hinj_q  <= hinj_d;
      hvld_q  <= hvld_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
